row_merge_sequencer: RTL
========================

// Module: row_merge_sequencer
// PURPOSE
//  Multi-cycle slide-and-merge engine for one 4-tile row of the 2048 board, toward tile 0.
//  Accepts a row of tile exponents (0 = empty, e = value 2^e) on a start strobe.
//  Compacts, merges equal neighbours once per move, compacts again, then reports result, moved flag and score gain.
//  Upstream of the per-tile cell registers: row_out is loaded into the cells via their preset path on done.
// PARAMETERS
//  TILE_W   4   bits per tile exponent; MAX_EXP = 2^TILE_W-1 (15)
//  SCORE_W  17  width of score_add; must hold 2 * 2^MAX_EXP
// PORTS
//  clk          in   1          single clock, rising edge
//  rst          in   1          synchronous, active-low reset
//  start        in   1          request; sampled only in IDLE
//  row_in       in   4*TILE_W   tile0 = [TILE_W-1:0] (leading edge) .. tile3 = MSBs
//  busy         out  1          high from the cycle after start is accepted until done
//  done         out  1          one-cycle pulse; row_out/moved/score_add/merge_count valid from then on
//  row_out      out  4*TILE_W   resulting row, same packing as row_in
//  moved        out  1          1 if row_out != row_in of the accepted request
//  merge_count  out  2          number of merges performed (0..2)
//  score_add    out  SCORE_W    sum of 2^(e+1) over merges
// BEHAVIOUR
//  Reset (rst==0 at an edge): state=IDLE; busy=0, done=0, row_out=0, moved=0, merge_count=0, score_add=0.
//   A reset in any state aborts the operation. No done is issued.
//  States: IDLE -> COMPACT1 -> MERGE -> COMPACT2 -> DONE -> IDLE.
//  IDLE: if start, latch row_in into work[0..3] and orig; clear score/merge accumulators; busy<=1; go to COMPACT1.
//  COMPACT1/COMPACT2, each cycle:
//   - "compacted" means no zero tile at a lower index than a nonzero tile.
//   - If not compacted: find the lowest index z with work[z]==0 and some nonzero above it.
//     Then work[i]<=work[i+1] for i>=z, work[3]<=0, and stay in the state.
//   - If compacted: leave unchanged. COMPACT1 goes to MERGE with p<=0; COMPACT2 goes to DONE.
//  MERGE, pointer p, one step per cycle:
//   - If work[p]!=0 && work[p]==work[p+1] && work[p]!=MAX_EXP: work[p]<=work[p]+1, work[p+1]<=0,
//     score+=2^(work[p]+1), merge_count+=1, p<=p+2.
//   - Otherwise p<=p+1.
//   - When p>=3 at the start of a cycle, go to COMPACT2 with no change.
//   - A merged tile never merges again in the same move. Pairs are resolved from tile 0 upward.
//  MAX_EXP tiles saturate: they never merge, so no exponent overflow is possible.
//  DONE (1 cycle): row_out<=work, moved<=(work!=orig), merge_count/score_add<=accumulators, done<=1, busy<=0.
//   Next state IDLE.
//  Outputs are registered. row_out/moved/merge_count/score_add hold until the next done or reset.
//  start while busy or in DONE is ignored (not queued). start in the cycle after done is accepted.
//  Latency: done at most 12 cycles after the accepting edge (COMPACT1<=4, MERGE<=4, COMPACT2<=3, DONE 1).
//  score arithmetic: 2^(e+1) computed as a SCORE_W-bit shift. The sum of two terms never overflows SCORE_W.
// STRUCTURE
//  Shared package/header (game_pkg): TILE_W, MAX_EXP, SCORE_W, state encodings, row pack/unpack macros,
//   exp_to_score function. The same package is used by the board controller and the tile cells.
//  Sub-module: row_compact_step (combinational). Outputs the one-pass shifted row and a compacted flag.
//   One instance is reused by COMPACT1 and COMPACT2.
//  Top: FSM, work/orig registers, merge pointer, accumulators, output registers.
// TESTING  (rows written tile0..tile3)
//  [1,1,1,1] -> row_out [2,2,0,0], merge_count 2, score_add 8, moved 1.
//  [2,2,2,0] -> [3,2,0,0], merge_count 1, score 8, moved 1. [0,2,0,2] -> [3,0,0,0], score 8, moved 1.
//  [1,2,3,4] and [0,0,0,0] -> row unchanged, moved 0, merge_count 0, score 0.
//   done still pulses within 12 cycles.
//  [15,15,0,0] -> unchanged, moved 0, score 0 (saturation). [14,14,0,0] -> [15,0,0,0], score 32768.
//  start held high continuously with random rows -> exactly one done per accepted request.
//   Requests arriving while busy are dropped. busy/done never high together.
//  rst=0 asserted in MERGE -> next cycle busy=0, done=0, row_out=0. A new start after release behaves normally.

Source files
------------

// File: rtl/row_merge_sequencer_pkg.sv
// Shared definitions for the row merge engine: widths, state codes, row helpers.
//   TILE_W/ROW_W/SCORE_W  bus widths
//   S_*                   FSM state encodings
//   get_tile/set_tile     row packing helpers (tile0 in the LSBs)
//   exp_to_score          2^(e+1) as a SCORE_W-bit value
package row_merge_sequencer_pkg;

  localparam int unsigned TILE_W  = 4;
  localparam int unsigned N_TILES = 4;
  localparam int unsigned ROW_W   = N_TILES * TILE_W;
  localparam int unsigned SCORE_W = 17;
  localparam int unsigned PTR_W   = 3;
  localparam int unsigned MC_W    = 2;

  typedef logic [TILE_W-1:0] tile_t;
  typedef logic [ROW_W-1:0]  row_t;

  localparam tile_t MAX_EXP = '1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COMPACT1 = 3'd1;
  localparam logic [2:0] S_MERGE    = 3'd2;
  localparam logic [2:0] S_COMPACT2 = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  // Result payload presented on done
  typedef struct packed {
    row_t               row;
    logic               moved;
    logic [MC_W-1:0]    merge_count;
    logic [SCORE_W-1:0] score;
  } result_t;

  function automatic tile_t get_tile(input row_t row, input int unsigned idx);
    return row[idx*TILE_W +: TILE_W];
  endfunction

  function automatic row_t set_tile(input row_t row, input int unsigned idx, input tile_t v);
    row_t r;
    r = row;
    r[idx*TILE_W +: TILE_W] = v;
    return r;
  endfunction

  function automatic logic [SCORE_W-1:0] exp_to_score(input tile_t e);
    return SCORE_W'(1) << (32'(e) + 32'd1);
  endfunction

endpackage

// File: rtl/row_merge_sequencer_if.sv
// Request/result bus of the row merge engine.
//   start/row_in                       request from the board controller
//   busy/done/row_out/moved/
//   merge_count/score_add              status and result back to the controller
interface row_merge_sequencer_if
  import row_merge_sequencer_pkg::*;
();
  logic               start;
  row_t               row_in;
  logic               busy;
  logic               done;
  row_t               row_out;
  logic               moved;
  logic [MC_W-1:0]    merge_count;
  logic [SCORE_W-1:0] score_add;

  modport master (
    output start, row_in,
    input  busy, done, row_out, moved, merge_count, score_add
  );

  modport slave (
    input  start, row_in,
    output busy, done, row_out, moved, merge_count, score_add
  );
endinterface

// File: rtl/row_merge_sequencer_compact_step.sv
// One compaction pass over a row toward tile 0 (combinational).
//   i_row           row to compact
//   o_row_c         row with tiles from the lowest hole upward shifted down by one
//   o_compacted_c   1 when no empty tile sits below a nonzero tile (o_row_c == i_row)
module row_compact_step
  import row_merge_sequencer_pkg::*;
(
  input  row_t i_row,
  output row_t o_row_c,
  output logic o_compacted_c
);
  logic [N_TILES-1:0] w_hole;
  logic [N_TILES-1:0] w_shift;
  row_t               w_down;

  // Whole row moved one tile toward tile 0, zero fill at tile 3
  assign w_down = {TILE_W'(0), i_row[ROW_W-1:TILE_W]};

  always_comb begin
    logic nz_above;
    logic seen_hole;
    w_hole    = '0;
    w_shift   = '0;
    nz_above  = 1'b0;
    seen_hole = 1'b0;
    // A hole is an empty tile with any nonzero tile above it
    for (int i = int'(N_TILES) - 1; i >= 0; i--) begin
      w_hole[i] = (get_tile(i_row, 32'(i)) == '0) && nz_above;
      nz_above  = nz_above || (get_tile(i_row, 32'(i)) != '0);
    end
    // Every tile from the lowest hole upward takes its upper neighbour
    for (int i = 0; i < int'(N_TILES); i++) begin
      seen_hole  = seen_hole || w_hole[i];
      w_shift[i] = seen_hole;
    end
  end

  assign o_compacted_c = ~|w_hole;

  always_comb begin
    o_row_c = i_row;
    for (int i = 0; i < int'(N_TILES); i++) begin
      if (w_shift[i]) begin
        o_row_c[i*TILE_W +: TILE_W] = w_down[i*TILE_W +: TILE_W];
      end
    end
  end
endmodule

// File: rtl/row_merge_sequencer.sv
// Multi-cycle slide-and-merge of one 4-tile 2048 row toward tile 0.
//   clk   rising-edge clock
//   rst   synchronous active-low reset
//   bus   slave side of row_merge_sequencer_if (start/row_in in; busy/done/results out)
module row_merge_sequencer
  import row_merge_sequencer_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  row_merge_sequencer_if.slave bus
);
  logic [2:0]         r_state,  w_state_nxt;
  row_t               r_work,   w_work_nxt;
  row_t               r_orig,   w_orig_nxt;
  logic [PTR_W-1:0]   r_ptr,    w_ptr_nxt;
  logic [SCORE_W-1:0] r_score,  w_score_nxt;
  logic [MC_W-1:0]    r_merges, w_merges_nxt;
  logic               r_busy,   w_busy_nxt;
  logic               r_done,   w_done_nxt;
  result_t            r_res,    w_res_nxt;

  row_t               w_compact_row;
  logic               w_compacted;
  logic [1:0]         w_idx;
  tile_t              w_cur;
  tile_t              w_nbr;
  logic               w_can_merge;

  row_compact_step u_compact (
    .i_row         (r_work),
    .o_row_c       (w_compact_row),
    .o_compacted_c (w_compacted)
  );

  // Merge candidate pair at the pointer; index wraps at 3 but is only used when ptr < 3
  assign w_idx       = r_ptr[1:0];
  assign w_cur       = get_tile(r_work, 32'(w_idx));
  assign w_nbr       = get_tile(r_work, 32'(w_idx + 2'd1));
  assign w_can_merge = (w_cur != '0) && (w_cur == w_nbr) && (w_cur != MAX_EXP);

  // State register and all datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_work   <= '0;
      r_orig   <= '0;
      r_ptr    <= '0;
      r_score  <= '0;
      r_merges <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_res    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_work   <= w_work_nxt;
      r_orig   <= w_orig_nxt;
      r_ptr    <= w_ptr_nxt;
      r_score  <= w_score_nxt;
      r_merges <= w_merges_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_res    <= w_res_nxt;
    end
  end

  // Next-state and next-register logic
  always_comb begin
    w_state_nxt  = r_state;
    w_work_nxt   = r_work;
    w_orig_nxt   = r_orig;
    w_ptr_nxt    = r_ptr;
    w_score_nxt  = r_score;
    w_merges_nxt = r_merges;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_res_nxt    = r_res;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_work_nxt   = bus.row_in;
          w_orig_nxt   = bus.row_in;
          w_score_nxt  = '0;
          w_merges_nxt = '0;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = S_COMPACT1;
        end
      end

      S_COMPACT1: begin
        if (!w_compacted) begin
          w_work_nxt = w_compact_row;
        end else begin
          w_ptr_nxt   = '0;
          w_state_nxt = S_MERGE;
        end
      end

      S_MERGE: begin
        if (r_ptr >= PTR_W'(3)) begin
          w_state_nxt = S_COMPACT2;
        end else if (w_can_merge) begin
          // Skip past the freshly merged tile so it cannot merge again this move
          w_work_nxt   = set_tile(set_tile(r_work, 32'(w_idx), w_cur + TILE_W'(1)),
                                  32'(w_idx + 2'd1), '0);
          w_score_nxt  = r_score + exp_to_score(w_cur);
          w_merges_nxt = r_merges + MC_W'(1);
          w_ptr_nxt    = r_ptr + PTR_W'(2);
        end else begin
          w_ptr_nxt = r_ptr + PTR_W'(1);
        end
      end

      S_COMPACT2: begin
        if (!w_compacted) begin
          w_work_nxt = w_compact_row;
        end else begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        w_res_nxt.row         = r_work;
        w_res_nxt.moved       = (r_work != r_orig);
        w_res_nxt.merge_count = r_merges;
        w_res_nxt.score       = r_score;
        w_done_nxt            = 1'b1;
        w_busy_nxt            = 1'b0;
        w_state_nxt           = S_IDLE;
      end

      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.row_out     = r_res.row;
  assign bus.moved       = r_res.moved;
  assign bus.merge_count = r_res.merge_count;
  assign bus.score_add   = r_res.score;
endmodule
